grid_matrix_scanner: RTL



---
 rtl/grid_matrix_scanner.sv | 135 +++++++++++++
 1 files changed

// File: rtl/grid_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : grid_matrix_scanner
//  Purpose  : Double-buffered 8x8 LED row scanner with inter-row blanking and
//             per-frame live-cell population count.
//  Revision : 1.0 - initial release
// ============================================================================
module grid_matrix_scanner #(
    parameter int DWELL = 1000,
    parameter int BLANK = 8
) (
    input  logic        clka,
    input  logic        rst_n,
    input  logic [63:0] grid,
    input  logic        grid_load,
    input  logic        enable,
    output logic [7:0]  row_n,
    output logic [7:0]  col,
    output logic        frame_done,
    output logic [6:0]  population,
    output logic        pending
);

    localparam int c_cnt_w = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DWELL - 1);
    localparam logic [c_cnt_w-1:0] c_blank    = c_cnt_w'(BLANK);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    generate
        if ((DWELL < 2) || (BLANK < 0) || (BLANK >= DWELL)) begin : g_param_check
            $error("grid_matrix_scanner: need DWELL >= 2 and 0 <= BLANK < DWELL");
        end
    endgenerate

    logic [63:0]        r_shadow;
    logic [63:0]        r_disp;
    logic               r_pending;
    logic [2:0]         r_row;
    logic [c_cnt_w-1:0] r_cnt;
    logic [6:0]         r_acc;
    logic [7:0]         r_row_n;
    logic [7:0]         r_col;
    logic               r_frame_done;
    logic [6:0]         r_population;

    logic [7:0]         w_row_bits;
    logic [3:0]         w_row_pop;
    logic               w_slot_end;
    logic               w_boundary;
    logic               w_transfer;

    assign w_row_bits = r_disp[{r_row, 3'b000} +: 8];
    assign w_slot_end = enable && (r_cnt == c_cnt_last);
    assign w_boundary = w_slot_end && (r_row == 3'd7);
    // While disabled the display buffer tracks the shadow so re-enable is current.
    assign w_transfer = r_pending && (w_boundary || !enable);

    always_comb begin
        w_row_pop = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_row_pop = w_row_pop + {3'b000, w_row_bits[i]};
        end
    end

    // Buffers: a load on a transfer cycle lands in shadow while disp takes the old shadow.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow  <= 64'd0;
            r_disp    <= 64'd0;
            r_pending <= 1'b0;
        end else begin
            if (grid_load) begin
                r_shadow <= grid;
            end
            if (w_transfer) begin
                r_disp <= r_shadow;
            end
            if (grid_load) begin
                r_pending <= 1'b1;
            end else if (w_transfer) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_row        <= 3'd0;
            r_cnt        <= '0;
            r_acc        <= 7'd0;
            r_population <= 7'd0;
        end else if (!enable) begin
            r_row <= 3'd0;
            r_cnt <= '0;
            r_acc <= 7'd0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_row <= r_row + 3'd1;
            if (w_boundary) begin
                r_population <= r_acc + {3'b000, w_row_pop};
                r_acc        <= 7'd0;
            end else begin
                r_acc <= r_acc + {3'b000, w_row_pop};
            end
        end else begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    // Drivers are registered from the current counter state, lagging it by one cycle.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_row_n      <= 8'hFF;
            r_col        <= 8'h00;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_boundary;
            if (!enable || (r_cnt < c_blank)) begin
                r_row_n <= 8'hFF;
                r_col   <= 8'h00;
            end else begin
                r_row_n <= ~(8'h01 << r_row);
                r_col   <= w_row_bits;
            end
        end
    end

    assign row_n      = r_row_n;
    assign col        = r_col;
    assign frame_done = r_frame_done;
    assign population = r_population;
    assign pending    = r_pending;

endmodule
`default_nettype wire
